router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router write path.
- Decodes the 2-bit destination of each incoming header and sequences the header, payload and parity bytes into the selected output FIFO.
- Drives the FIFO write/lfd strobes and the register-block control strobes.
- Handles FIFO-full back-pressure, destination-busy waits and per-port soft-reset timeouts.

Parameters:
- ADDR_W, 2, width of destination address field (data_in[1:0]); value 3 is invalid.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- pkt_valid  input  1  high while header/payload bytes are presented; falls with the parity byte.
- data_in  input  ADDR_W  destination address bits of the header byte.
- fifo_full  input  1  full flag of the currently selected FIFO.
- fifo_empty_0/1/2  input  1 each  empty flags of FIFOs 0..2.
- soft_reset_0/1/2  input  1 each  per-port timeout soft resets.
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block saw pkt_valid fall while the FSM was stalled.
- detect_add  output  1  FSM in DECODE_ADDRESS.
- lfd_state  output  1  FSM in LOAD_FIRST_DATA (header write; FIFO tags byte as header).
- ld_state  output  1  FSM in LOAD_DATA.
- laf_state  output  1  FSM in LOAD_AFTER_FULL.
- full_state  output  1  FSM in FIFO_FULL_STATE.
- write_enb_reg  output  1  write enable to FIFO/register path.
- rst_int_reg  output  1  FSM in CHECK_PARITY_ERROR; clears internal parity registers.
- busy  output  1  stall indication to the source.

Behaviour:
- Eight states, one-hot or binary, implementer's choice: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- resetn low: state = DECODE_ADDRESS and addr_q = 0, asynchronously.
- Reset output values: detect_add=1; all other outputs 0.
- All outputs are Moore, decoded from state only, with no added register latency:
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
  - Each state flag is high only in its own state.
- addr_q is captured from data_in on the clock edge leaving DECODE_ADDRESS. It is used for empty/soft-reset selection until the next DECODE_ADDRESS.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in<3, fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in<3, fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay. An invalid-address packet is dropped.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE. Full has priority over pkt_valid falling.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
- Soft reset:
  - soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS on the next edge, overriding all other transitions.
  - soft_reset of a non-selected port is ignored.
- Header-to-first-payload timing: header accepted in DECODE_ADDRESS; lfd_state high on the next cycle; payload writes follow every cycle in LOAD_DATA.
- resetn asserted mid-packet: immediate return to DECODE_ADDRESS. No partial-packet recovery.

Test Plan:
- Reset, then header 8'h11 (len 4, addr 1), pkt_valid=1, fifo_empty_1=1 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA for 4 cycles (write_enb_reg=1, busy=0). pkt_valid falls -> LOAD_PARITY -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS (detect_add=1).
- Header addr 2 with fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1 held. Raise fifo_empty_2 after 5 cycles -> LOAD_FIRST_DATA the following cycle.
- fifo_full=1 in LOAD_DATA on payload byte 2 -> FIFO_FULL_STATE (full_state=1, write_enb_reg=0). Drop fifo_full -> LOAD_AFTER_FULL, then with low_pkt_valid=0 and parity_done=0 -> LOAD_DATA.
- LOAD_AFTER_FULL with low_pkt_valid=1 -> LOAD_PARITY. Separate run with parity_done=1 -> DECODE_ADDRESS.
- Header addr 3 with pkt_valid=1 -> FSM remains in DECODE_ADDRESS, write_enb_reg=0 throughout.
- In WAIT_TILL_EMPTY for addr 0: soft_reset_1=1 -> no effect; soft_reset_0=1 -> DECODE_ADDRESS next edge. resetn=0 mid-LOAD_DATA -> detect_add=1 immediately (asynchronous).

Source files
------------

// File: rtl/router_fsm_if.sv
// Router write-path control bundle.
// Groups everything between the router FSM and its surroundings except
// clock/reset: the source handshake (pkt_valid, data_in), FIFO status
// (fifo_full, fifo_empty_*), per-port soft resets, register-block status
// (parity_done, low_pkt_valid) and the FSM's state/strobe outputs.
//   slave  : the FSM side (consumes status, drives strobes)
//   master : the environment side (drives status, observes strobes)
interface router_fsm_if #(
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router write path.
// Decodes the destination of each header, sequences header/payload/parity
// writes into the selected FIFO, and handles FIFO-full stalls, waits for a
// busy destination and per-port soft-reset timeouts.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : router_fsm_if.slave (handshake, FIFO status, strobes)
//
// state              | meaning
// -------------------+----------------------------------------------------
// DECODE_ADDRESS     | idle, waiting for a header with a valid destination
// LOAD_FIRST_DATA    | header byte written, FIFO tags it as first byte
// LOAD_DATA          | payload bytes written every cycle
// FIFO_FULL_STATE    | destination FIFO full, writes held off
// LOAD_AFTER_FULL    | byte held during the stall is written
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity compare, internal parity registers cleared
// WAIT_TILL_EMPTY    | destination still draining a previous packet
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic        clock,
  input  logic        resetn,
  router_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;

  // Padded to four entries so address 3 selects a constant 0 instead of
  // indexing out of range.
  logic [3:0] empty_vec;
  logic [3:0] soft_vec;
  logic       addr_ok;
  logic       empty_in;
  logic       empty_q;
  logic       soft_q;

  assign empty_vec = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_vec  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign addr_ok   = (bus.data_in < ADDR_W'(3));
  assign empty_in  = empty_vec[bus.data_in[1:0]];
  assign empty_q   = empty_vec[addr_q[1:0]];
  assign soft_q    = soft_vec[addr_q[1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && state_nxt != DECODE_ADDRESS) begin
        addr_q <= bus.data_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && addr_ok) begin
          state_nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        // Full wins over pkt_valid falling: the current byte must not be lost.
        if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
        else                        state_nxt = LOAD_DATA;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_q) state_nxt = LOAD_FIRST_DATA;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    // A timeout on the port in use abandons the packet from any busy state.
    if (state != DECODE_ADDRESS && soft_q) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  always_comb begin
    bus.detect_add    = (state == DECODE_ADDRESS);
    bus.lfd_state     = (state == LOAD_FIRST_DATA);
    bus.ld_state      = (state == LOAD_DATA);
    bus.laf_state     = (state == LOAD_AFTER_FULL);
    bus.full_state    = (state == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY);
    bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;
  localparam int ADDR_W = 2;

  logic clock;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  router_fsm_if #(.ADDR_W(ADDR_W)) bus ();

  router_fsm #(.ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural reference ----------------
  // Packet phases of the write path; the model tracks which phase the
  // current packet is in and which port it targets.
  typedef enum int {P_IDLE, P_HDR, P_PAY, P_STALL, P_RESUME, P_PAR, P_CHK, P_WAIT} phase_t;
  phase_t m_ph   = P_IDLE;
  int     m_port = 0;

  function automatic logic port_empty(input int p);
    if (p == 0) return bus.fifo_empty_0;
    if (p == 1) return bus.fifo_empty_1;
    if (p == 2) return bus.fifo_empty_2;
    return 1'b0;
  endfunction

  function automatic logic port_soft(input int p);
    if (p == 0) return bus.soft_reset_0;
    if (p == 1) return bus.soft_reset_1;
    if (p == 2) return bus.soft_reset_2;
    return 1'b0;
  endfunction

  // {detect, lfd, ld, laf, full, wen, rst_int, busy}
  function automatic logic [7:0] exp_out(input phase_t p);
    logic writing;
    logic idle_or_pay;
    writing     = (p == P_PAY) || (p == P_RESUME) || (p == P_PAR);
    idle_or_pay = (p == P_IDLE) || (p == P_PAY);
    return {p == P_IDLE, p == P_HDR, p == P_PAY, p == P_RESUME, p == P_STALL,
            writing, p == P_CHK, !idle_or_pay};
  endfunction

  initial begin
    int dest;
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_ph   = P_IDLE;
        m_port = 0;
      end else if (m_ph != P_IDLE && port_soft(m_port)) begin
        m_ph = P_IDLE;
      end else begin
        case (m_ph)
          P_IDLE: begin
            dest = int'(bus.data_in);
            if (bus.pkt_valid && dest < 3) begin
              m_port = dest;
              m_ph   = port_empty(dest) ? P_HDR : P_WAIT;
            end
          end
          P_HDR:    m_ph = P_PAY;
          P_PAY:    m_ph = bus.fifo_full ? P_STALL : (!bus.pkt_valid ? P_PAR : P_PAY);
          P_STALL:  m_ph = bus.fifo_full ? P_STALL : P_RESUME;
          P_RESUME: m_ph = bus.parity_done ? P_IDLE : (bus.low_pkt_valid ? P_PAR : P_PAY);
          P_PAR:    m_ph = P_CHK;
          P_CHK:    m_ph = bus.fifo_full ? P_STALL : P_IDLE;
          P_WAIT:   m_ph = port_empty(m_port) ? P_HDR : P_WAIT;
          default:  m_ph = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [7:0] act;
    logic [7:0] exp;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
               bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
        exp = exp_out(m_ph);
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t {det,lfd,ld,laf,full,wen,rst,busy} got %b expected %b",
                   $time, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.pkt_valid     = 1'b0;
    bus.data_in       = '0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1 chk_en = 1'b1;
    #20;
    chk("reset_detect_add", bus.detect_add, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_wen", bus.write_enb_reg, 1'b0);
    resetn = 1'b1;

    // Header 8'h11 to port 1, four payload cycles, parity, check.
    step();
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd1;
    step();
    chk("hdr_lfd", bus.lfd_state, 1'b1);
    chk("hdr_busy", bus.busy, 1'b1);
    chk("model_pin_hdr", logic'(m_ph == P_HDR), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pay_wen", bus.write_enb_reg, 1'b1);
      chk("pay_busy", bus.busy, 1'b0);
    end
    bus.pkt_valid = 1'b0;
    step();
    chk("parity_wen", bus.write_enb_reg, 1'b1);
    step();
    chk("chk_rst_int", bus.rst_int_reg, 1'b1);
    step();
    chk("back_detect", bus.detect_add, 1'b1);

    // Port 2 busy: wait five cycles, then header goes out.
    bus.pkt_valid    = 1'b1;
    bus.data_in      = 2'd2;
    bus.fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_busy", bus.busy, 1'b1);
      chk("wait_no_lfd", bus.lfd_state, 1'b0);
    end
    bus.fifo_empty_2 = 1'b1;
    step();
    chk("wait_then_lfd", bus.lfd_state, 1'b1);
    step();
    step();
    bus.fifo_full = 1'b1;
    step();
    chk("full_state", bus.full_state, 1'b1);
    chk("full_no_wen", bus.write_enb_reg, 1'b0);
    bus.fifo_full = 1'b0;
    step();
    chk("laf_state", bus.laf_state, 1'b1);
    chk("laf_wen", bus.write_enb_reg, 1'b1);
    step();
    chk("laf_to_ld", bus.ld_state, 1'b1);

    // Stall again, resume with low_pkt_valid -> parity.
    bus.fifo_full = 1'b1;
    step();
    bus.fifo_full = 1'b0;
    step();
    bus.low_pkt_valid = 1'b1;
    bus.pkt_valid     = 1'b0;
    step();
    chk("laf_low_to_parity", bus.write_enb_reg & bus.busy, 1'b1);
    bus.low_pkt_valid = 1'b0;
    step();
    step();
    chk("low_run_idle", bus.detect_add, 1'b1);

    // Port 0 packet, stall, resume with parity_done -> idle.
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd0;
    step();
    step();
    bus.fifo_full = 1'b1;
    step();
    bus.fifo_full = 1'b0;
    step();
    bus.parity_done = 1'b1;
    bus.pkt_valid   = 1'b0;
    step();
    chk("laf_parity_done_idle", bus.detect_add, 1'b1);
    bus.parity_done = 1'b0;

    // Invalid address 3 is dropped.
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("addr3_stay", bus.detect_add, 1'b1);
      chk("addr3_no_wen", bus.write_enb_reg, 1'b0);
    end

    // Soft reset selection while waiting on port 0.
    bus.data_in      = 2'd0;
    bus.fifo_empty_0 = 1'b0;
    step();
    bus.pkt_valid    = 1'b0;
    bus.soft_reset_1 = 1'b1;
    step();
    chk("other_soft_ignored", bus.busy & ~bus.detect_add, 1'b1);
    bus.soft_reset_1 = 1'b0;
    bus.soft_reset_0 = 1'b1;
    step();
    chk("own_soft_idle", bus.detect_add, 1'b1);
    bus.soft_reset_0 = 1'b0;
    bus.fifo_empty_0 = 1'b1;

    // Asynchronous reset in the middle of payload.
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd1;
    step();
    step();
    chk("pre_reset_ld", bus.ld_state, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_detect", bus.detect_add, 1'b1);
    chk("async_reset_ld", bus.ld_state, 1'b0);
    #4 resetn = 1'b1;
    idle_inputs();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      bus.pkt_valid     = ($urandom_range(0, 3) != 0);
      bus.data_in       = ADDR_W'($urandom_range(0, 3));
      bus.fifo_full     = ($urandom_range(0, 3) == 0);
      bus.fifo_empty_0  = $urandom_range(0, 1) == 1;
      bus.fifo_empty_1  = $urandom_range(0, 1) == 1;
      bus.fifo_empty_2  = $urandom_range(0, 1) == 1;
      bus.soft_reset_0  = ($urandom_range(0, 31) == 0);
      bus.soft_reset_1  = ($urandom_range(0, 31) == 0);
      bus.soft_reset_2  = ($urandom_range(0, 31) == 0);
      bus.parity_done   = ($urandom_range(0, 7) == 0);
      bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0;
        #4 resetn = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
